// File: rtl/skew_feed_ctrl.sv
// skew_feed_ctrl: feeds one burst of vectors into a systolic skew chain, then drains it and pulses done
module skew_feed_ctrl #(
  parameter int DW    = 64,
  parameter int DN    = 8,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_data,
  output logic [DW-1:0]    chain_xi,
  output logic [DN-1:0]    lane_vld,
  output logic             busy,
  output logic             done
);
  localparam int DCW = $clog2(DN);
  localparam logic [DCW-1:0] DLAST = DCW'(DN - 1);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [DCW-1:0]   dcnt;
  logic             issue_q;
  logic [DN-2:0]    hist;
  logic             accept;
  assign accept   = s_valid && s_ready;
  assign s_ready  = state == FEED;
  assign busy     = state != IDLE;
  assign done     = state == DONE;
  // lane i sees a beat i cycles after it left the controller
  assign lane_vld = {hist, issue_q};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      len_q    <= '0;
      cnt      <= '0;
      dcnt     <= '0;
      issue_q  <= 1'b0;
      hist     <= '0;
      chain_xi <= '0;
    end else begin
      chain_xi <= accept ? s_data : '0;
      issue_q  <= accept;
      hist     <= lane_vld[DN-2:0];
      case (state)
        IDLE: if (start) begin
          len_q <= len;
          cnt   <= '0;
          dcnt  <= '0;
          state <= (len == '0) ? DONE : FEED;
        end
        FEED: if (accept) begin
          cnt <= cnt + 1'b1;
          if ((cnt + 1'b1) == len_q) state <= DRAIN;
        end
        DRAIN: begin
          dcnt  <= (dcnt == DLAST) ? '0 : dcnt + 1'b1;
          state <= (dcnt == DLAST) ? DONE : DRAIN;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_skew_feed_ctrl.sv
// tb_skew_feed_ctrl: directed bursts checked every cycle against a timeline model plus pinned literals
module tb_skew_feed_ctrl;
  localparam int DW = 64, DN = 8, LEN_W = 8, HN = 4096;
  logic clk = 0, rst_n = 0, start = 0, s_valid = 0;
  logic [LEN_W-1:0] len = '0;
  logic [DW-1:0] s_data = '0;
  logic s_ready, busy, done;
  logic [DW-1:0] chain_xi;
  logic [DN-1:0] lane_vld;
  int checks = 0, failures = 0, dut_acc = 0, seq = 0, cyc = 0, m_left = 0, m_done_at = -10;
  bit m_idle = 1;
  bit acc_at [HN];
  logic [DW-1:0] m_xi = '0;

  skew_feed_ctrl #(.DW(DW), .DN(DN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .s_valid(s_valid),
    .s_ready(s_ready), .s_data(s_data), .chain_xi(chain_xi), .lane_vld(lane_vld),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    seq++;
    s_data = {32'(seq) | 32'hA5000000, ~32'(seq)};
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 400) begin
      tick();
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  // Timeline model: remembers which cycle each beat was accepted in; lane i is valid i cycles later
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_idle = 1; m_left = 0; m_done_at = -10; m_xi = '0;
      foreach (acc_at[i]) acc_at[i] = 0;
    end else begin
      bit acc, was_idle;
      acc = s_valid && (m_left > 0);
      was_idle = m_idle;
      cyc++;
      acc_at[cyc % HN] = acc;
      m_xi = acc ? s_data : '0;
      if (acc) begin
        m_left--;
        if (m_left == 0) m_done_at = cyc + DN;
      end else if (was_idle && start) begin
        m_idle = 0;
        if (len == 0) m_done_at = cyc;
        else m_left = int'(len);
      end
      if (cyc == m_done_at + 1) m_idle = 1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      logic [DN-1:0] ev;
      for (int i = 0; i < DN; i++) ev[i] = (cyc - i >= 0) ? acc_at[(cyc - i) % HN] : 1'b0;
      chk("m_busy", busy, !m_idle);
      chk("m_done", done, cyc == m_done_at);
      chk("m_ready", s_ready, m_left > 0);
      chk("m_lane_vld", lane_vld, ev);
      chk("m_chain_xi", chain_xi, m_xi);
      if (s_valid && s_ready) dut_acc++;
    end
  end

  initial begin
    int n, a0;
    logic [DN-1:0] b2b [11];
    b2b = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1E, 8'h3C, 8'h78, 8'hF0, 8'hE0, 8'hC0, 8'h80};
    repeat (3) tick();
    rst_n = 1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_lane", lane_vld, 0);
    chk("rst_ready", s_ready, 0);

    // async reset in the middle of FEED
    start = 1; len = 4; tick(); start = 0; s_valid = 1;
    tick(); tick();
    chk("pre_rst_lane", lane_vld, 8'h03);
    #2 rst_n = 0;
    #1;
    chk("arst_xi", chain_xi, 0);
    chk("arst_lane", lane_vld, 0);
    chk("arst_ctl", {busy, done, s_ready}, 0);
    s_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_lane", lane_vld, 0);

    // single beat
    start = 1; len = 1; tick(); start = 0;
    s_valid = 1; s_data = 64'h0807060504030201; a0 = dut_acc;
    tick(); s_valid = 0;
    chk("one_xi", chain_xi, 64'h0807060504030201);
    chk("one_lane1", lane_vld, 8'h01);
    repeat (7) tick();
    chk("one_lane8", lane_vld, 8'h80);
    tick();
    chk("one_done", done, 1);
    tick();
    chk("one_busy_drop", busy, 0);
    chk("one_accepts", dut_acc - a0, 1);

    // back-to-back, second beat is all zeros
    start = 1; len = 4; tick(); start = 0; s_valid = 1; a0 = dut_acc;
    for (int k = 0; k < 11; k++) begin
      tick();
      if (k == 0) s_data = '0;
      chk($sformatf("b2b_lane_%0d", k + 1), lane_vld, b2b[k]);
    end
    chk("b2b_no_done_early", done, 0);
    tick();
    chk("b2b_done", done, 1);
    chk("b2b_accepts", dut_acc - a0, 4);
    s_valid = 0; tick();

    // bubbles 1,0,1,0,1
    start = 1; len = 3; tick(); start = 0; s_valid = 1;
    tick(); s_valid = 0; chk("bub_l1", lane_vld, 8'h01);
    tick(); s_valid = 1; chk("bub_l2", lane_vld, 8'h02); chk("bub_xi0", chain_xi, 0);
    tick(); s_valid = 0; chk("bub_l3", lane_vld, 8'h05);
    tick(); s_valid = 1; chk("bub_l4", lane_vld, 8'h0A);
    tick(); s_valid = 0; chk("bub_l5", lane_vld, 8'h15);
    wait_done(n);
    chk("bub_done_lat", n, 8);
    tick();

    // zero-length burst
    start = 1; len = 0; tick(); start = 0;
    chk("z_busy", busy, 1); chk("z_done", done, 1); chk("z_ready", s_ready, 0);
    tick();
    chk("z_busy_drop", busy, 0); chk("z_lane", lane_vld, 0);

    // start during FEED and DRAIN is ignored
    start = 1; len = 5; tick(); len = 2; a0 = dut_acc;
    tick(); tick(); start = 0; s_valid = 1;
    repeat (5) tick();
    s_valid = 1; start = 1; len = 3; tick(); start = 0; s_valid = 0;
    wait_done(n);
    chk("ign_done_lat", n, 7);
    chk("ign_accepts", dut_acc - a0, 5);
    tick();
    chk("ign_idle", busy, 0);

    // maximum length, no wrap
    start = 1; len = 8'hFF; tick(); start = 0; s_valid = 1; a0 = dut_acc;
    wait_done(n);
    chk("max_done_lat", n, 263);
    chk("max_accepts", dut_acc - a0, 255);
    s_valid = 0;
    tick(); tick();
    chk("max_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
